sram_bus_arbiter: RTL



---
 rtl/sram_bus_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: round-robin CPU/DMA arbiter for the byte-wide SRAM register bus,
// with a bounded DMA burst and a wait-state watchdog.
module sram_bus_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int MAX_BURST    = 4,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          cpu_cs,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d_out,
    output logic [DW-1:0] cpu_d_in,
    output logic          cpu_wait,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_a,
    input  logic [DW-1:0] dma_d_out,
    output logic [DW-1:0] dma_d_in,
    output logic          dma_gnt,
    output logic          dma_ack,
    output logic          tgt_cs,
    output logic          tgt_oe,
    output logic          tgt_we,
    output logic [AW-1:0] tgt_a,
    output logic [DW-1:0] tgt_d_out,
    input  logic [DW-1:0] tgt_d_in,
    input  logic          tgt_wait,
    output logic          timeout_err
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

    state_t        r_state, w_state_n;
    logic          r_last, w_last_n;
    logic [BW-1:0] r_burst, w_burst_n;
    logic [WW-1:0] r_wait, w_wait_n;
    logic          w_req, w_to, w_rdy;

    // r_last = 1 means D was served last, so C wins the next tie
    assign w_req = (r_state == OWN_C) ? cpu_cs : (r_state == OWN_D) ? dma_req : 1'b0;
    assign w_to  = (WAIT_TIMEOUT != 0) && w_req && tgt_wait && (r_wait == WMAX);
    assign w_rdy = ~tgt_wait | w_to;

    assign timeout_err = w_to;
    assign cpu_d_in    = (w_to && r_state == OWN_C) ? {DW{1'b1}} : tgt_d_in;
    assign dma_d_in    = (w_to && r_state == OWN_D) ? {DW{1'b1}} : tgt_d_in;

    always_comb begin
        w_state_n = r_state;
        w_last_n  = r_last;
        w_burst_n = r_burst;
        w_wait_n  = (w_req && tgt_wait && !w_to) ? r_wait + 1'b1 : '0;
        tgt_cs    = 1'b0;
        tgt_oe    = 1'b0;
        tgt_we    = 1'b0;
        tgt_a     = '0;
        tgt_d_out = '0;
        dma_gnt   = 1'b0;
        dma_ack   = 1'b0;
        cpu_wait  = cpu_cs;
        case (r_state)
            IDLE: begin
                w_state_n = (cpu_cs && (!dma_req || r_last)) ? OWN_C : dma_req ? OWN_D : IDLE;
            end
            OWN_C: begin
                tgt_cs    = cpu_cs;
                tgt_oe    = cpu_oe;
                tgt_we    = cpu_we;
                tgt_a     = cpu_a;
                tgt_d_out = cpu_d_out;
                cpu_wait  = cpu_cs & ~w_rdy;
                w_state_n = (!cpu_cs || w_rdy) ? IDLE : OWN_C;
                w_last_n  = (cpu_cs && w_rdy) ? 1'b0 : r_last;
            end
            OWN_D: begin
                tgt_cs    = 1'b1;
                tgt_oe    = ~dma_we;
                tgt_we    = dma_we;
                tgt_a     = dma_a;
                tgt_d_out = dma_d_out;
                dma_gnt   = 1'b1;
                dma_ack   = dma_req & w_rdy;
                if (dma_ack)
                    w_burst_n = (r_burst == BMAX) ? r_burst : r_burst + 1'b1;
                // the burst counter saturates so a late CPU request still forces a release
                if (!dma_req || (dma_ack && (w_to || (cpu_cs && r_burst == BMAX)))) begin
                    w_state_n = IDLE;
                    w_last_n  = 1'b1;
                    w_burst_n = '0;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_burst <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_n;
            r_last  <= w_last_n;
            r_burst <= w_burst_n;
            r_wait  <= w_wait_n;
        end
    end
endmodule
